// File: rtl/mon_pkg.sv
// ============================================================================
// mon_pkg : shared monitor definitions (default widths, output FSM states)
// Rev 1.0
// ============================================================================
`default_nettype none

package mon_pkg;

  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_ADDR_WIDTH = 5;

  typedef enum logic {
    NOVALID = 1'b0,
    VALID   = 1'b1
  } out_state_e;

endpackage : mon_pkg

`default_nettype wire

// File: rtl/mon_fifo_ctrl.sv
// ============================================================================
// mon_fifo_ctrl : FIFO controller for an external registered-read monitor RAM
// Rev 1.0
// ============================================================================
`default_nettype none

module mon_fifo_ctrl
  import mon_pkg::*;
#(
  parameter int DataWidth  = DEF_DATA_WIDTH,
  parameter int AddrWidth  = DEF_ADDR_WIDTH,
  parameter int AFullLevel = (2 ** AddrWidth) - 4
) (
  input  logic                 clk,
  input  logic                 Reset_b,
  input  logic                 Clear,
  input  logic                 WrEn,
  input  logic [DataWidth-1:0] WrData,
  input  logic                 RdReady,
  output logic                 RdValid,
  output logic [DataWidth-1:0] RdData,
  output logic                 Full,
  output logic                 AlmostFull,
  output logic                 Empty,
  output logic [AddrWidth:0]   Count,
  output logic                 Overflow,
  output logic [AddrWidth:0]   HighWater,
  output logic                 MemWrite,
  output logic [AddrWidth-1:0] MemWrAddr,
  output logic [DataWidth-1:0] MemInData,
  output logic [AddrWidth-1:0] MemRdAddr,
  input  logic [DataWidth-1:0] MemOutData
);

  localparam int                 RamSize   = 2 ** AddrWidth;
  localparam logic [AddrWidth:0] FULL_CNT  = (AddrWidth + 1)'(RamSize);
  localparam logic [AddrWidth:0] AFULL_CNT = (AddrWidth + 1)'(AFullLevel);
  localparam logic [AddrWidth:0] ZERO_CNT  = '0;

  logic [AddrWidth-1:0] wptr;
  logic [AddrWidth-1:0] rptr;
  logic [AddrWidth-1:0] rd_addr;
  logic [AddrWidth:0]   count;
  logic [AddrWidth:0]   count_next;
  logic [AddrWidth:0]   high_water;
  logic                 overflow;
  out_state_e           state;
  logic                 flush;
  logic                 push;
  logic                 pop;
  logic                 collide;

  assign flush = ~Reset_b | Clear;

  assign Full       = (count == FULL_CNT);
  assign Empty      = (count == ZERO_CNT);
  assign AlmostFull = (count >= AFULL_CNT);

  // Flush gates both handshakes so nothing reaches the RAM while clearing.
  assign push = WrEn & ~Full & ~flush;
  assign pop  = RdValid & RdReady & ~flush;

  // Look ahead one address on pop so the next head is ready a cycle later.
  assign rd_addr    = pop ? rptr + AddrWidth'(1) : rptr;
  assign count_next = count + {{AddrWidth{1'b0}}, push} - {{AddrWidth{1'b0}}, pop};
  assign collide    = push & (wptr == rd_addr);

  assign RdValid   = (state == VALID);
  assign RdData    = MemOutData;
  assign Count     = count;
  assign Overflow  = overflow;
  assign HighWater = high_water;
  assign MemWrite  = push;
  assign MemWrAddr = wptr;
  assign MemInData = WrData;
  assign MemRdAddr = rd_addr;

  always_ff @(posedge clk) begin
    if (flush) begin
      wptr       <= '0;
      rptr       <= '0;
      count      <= '0;
      high_water <= '0;
      overflow   <= 1'b0;
      state      <= NOVALID;
    end else begin
      if (push) wptr <= wptr + AddrWidth'(1);
      if (pop)  rptr <= rptr + AddrWidth'(1);
      count <= count_next;
      if (count_next > high_water) high_water <= count_next;
      if (WrEn && Full) overflow <= 1'b1;
      // A word written at the address being read is not visible until the next read.
      if ((count_next != ZERO_CNT) && !collide) state <= VALID;
      else                                      state <= NOVALID;
    end
  end

endmodule : mon_fifo_ctrl

`default_nettype wire

// File: tb/tb_mon_fifo_ctrl.sv
// ============================================================================
// tb_mon_fifo_ctrl : directed scoreboard bench with a registered-read RAM model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_mon_fifo_ctrl;

  logic        clk = 1'b0;
  logic        Reset_b = 1'b0;
  logic        Clear = 1'b0;
  logic        WrEn = 1'b0;
  logic [15:0] WrData = '0;
  logic        RdReady = 1'b0;
  logic        RdValid;
  logic [15:0] RdData;
  logic        Full, AlmostFull, Empty, Overflow;
  logic [5:0]  Count, HighWater;
  logic        MemWrite;
  logic [4:0]  MemWrAddr, MemRdAddr;
  logic [15:0] MemInData;
  logic [15:0] MemOutData;

  logic [15:0] mem [32];

  int total = 0;
  int bad   = 0;

  logic [15:0] q[$];
  int          mcount = 0;
  int          mhw    = 0;
  logic        movf   = 1'b0;

  mon_fifo_ctrl dut (
    .clk        (clk),
    .Reset_b    (Reset_b),
    .Clear      (Clear),
    .WrEn       (WrEn),
    .WrData     (WrData),
    .RdReady    (RdReady),
    .RdValid    (RdValid),
    .RdData     (RdData),
    .Full       (Full),
    .AlmostFull (AlmostFull),
    .Empty      (Empty),
    .Count      (Count),
    .Overflow   (Overflow),
    .HighWater  (HighWater),
    .MemWrite   (MemWrite),
    .MemWrAddr  (MemWrAddr),
    .MemInData  (MemInData),
    .MemRdAddr  (MemRdAddr),
    .MemOutData (MemOutData)
  );

  always #5 clk = ~clk;

  // Registered-read RAM, read-before-write on an address collision.
  always @(posedge clk) begin
    if (MemWrite) mem[MemWrAddr] <= MemInData;
    MemOutData <= mem[MemRdAddr];
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive at negedge, score the handshake, then check flags after the edge.
  task automatic step(input logic rb, input logic clr, input logic we,
                      input logic [15:0] wd, input logic rr, input int exp_rv);
    logic flush, did_push, did_pop;
    logic [15:0] exp_word;
    @(negedge clk);
    Reset_b = rb; Clear = clr; WrEn = we; WrData = wd; RdReady = rr;
    #1;
    flush    = !rb || clr;
    did_push = we && !flush && (mcount < 32);
    did_pop  = 1'b0;
    if (exp_rv >= 0) chk("rdvalid", RdValid, exp_rv[0]);
    chk("memwrite", MemWrite, did_push);
    if (!flush && RdValid === 1'b1) begin
      chk("sb_nonempty", q.size() != 0, 1);
      if (q.size() != 0) begin
        if (rr) begin
          exp_word = q.pop_front();
          chk("rddata", RdData, exp_word);
          did_pop = 1'b1;
        end else begin
          chk("head", RdData, q[0]);
        end
      end
    end
    if (flush) begin
      q.delete();
      mcount = 0; mhw = 0; movf = 1'b0;
    end else begin
      if (did_push) q.push_back(wd);
      if (we && mcount == 32) movf = 1'b1;
      mcount = mcount + int'(did_push) - int'(did_pop);
      if (mcount > mhw) mhw = mcount;
    end
    @(posedge clk);
    #1;
    chk("count", Count, mcount);
    chk("full", Full, mcount == 32);
    chk("empty", Empty, mcount == 0);
    chk("afull", AlmostFull, mcount >= 28);
    chk("overflow", Overflow, movf);
    chk("highwater", HighWater, mhw);
  endtask

  task automatic check_reset_outputs();
    chk("rst_rdvalid", RdValid, 0);
    chk("rst_full", Full, 0);
    chk("rst_afull", AlmostFull, 0);
    chk("rst_empty", Empty, 1);
    chk("rst_memwrite", MemWrite, 0);
    chk("rst_mrdaddr", MemRdAddr, 0);
    chk("rst_count", Count, 0);
    chk("rst_ovf", Overflow, 0);
    chk("rst_hw", HighWater, 0);
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && q.size() > 0; i++) step(1, 0, 0, 16'h0, 1, -1);
    chk("drain_done", q.size(), 0);
    step(1, 0, 0, 16'h0, 0, 0);
  endtask

  initial begin
    step(0, 0, 0, 16'h0, 0, -1);
    step(0, 0, 0, 16'h0, 0, -1);
    check_reset_outputs();

    // Single word into an empty FIFO: visible two cycles later.
    step(1, 0, 1, 16'hA001, 0, 0);
    step(1, 0, 0, 16'h0, 0, 0);
    step(1, 0, 0, 16'h0, 0, 1);
    step(1, 0, 0, 16'h0, 1, 1);
    step(1, 0, 0, 16'h0, 0, 0);

    // Fill to Full, overflow attempt, overflow while popping, then drain.
    for (int i = 0; i < 32; i++) step(1, 0, 1, 16'h1000 + 16'(i), 0, -1);
    step(1, 0, 1, 16'hDEAD, 0, 1);
    step(1, 0, 1, 16'hDEAD, 1, 1);
    drain();

    // Count=1 with simultaneous pop and push: one bubble cycle.
    step(1, 0, 1, 16'h1111, 0, 0);
    step(1, 0, 0, 16'h0, 0, 0);
    step(1, 0, 0, 16'h0, 0, 1);
    step(1, 0, 1, 16'hBEEF, 1, 1);
    step(1, 0, 0, 16'h0, 0, 0);
    step(1, 0, 0, 16'h0, 0, 1);
    drain();

    // Streaming across pointer wrap after a clean restart.
    step(1, 1, 0, 16'h0, 0, 0);
    for (int i = 0; i < 100; i++) step(1, 0, 1, 16'h5000 + 16'(i), 1, -1);
    drain();
    chk("hw_le2", HighWater <= 6'd2, 1);

    // Clear with a push pending.
    step(1, 1, 0, 16'h0, 0, 0);
    for (int i = 0; i < 10; i++) step(1, 0, 1, 16'h6000 + 16'(i), 0, -1);
    chk("pre_clear_count", Count, 10);
    step(1, 1, 1, 16'h7777, 0, -1);
    chk("clear_empty", Empty, 1);
    step(1, 0, 0, 16'h0, 0, 0);

    // Reset pulse while AlmostFull.
    for (int i = 0; i < 28; i++) step(1, 0, 1, 16'h8000 + 16'(i), 0, -1);
    chk("pre_rst_afull", AlmostFull, 1);
    step(0, 0, 0, 16'h0, 0, -1);
    check_reset_outputs();
    step(1, 0, 0, 16'h0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_mon_fifo_ctrl

`default_nettype wire

// File: doc/mon_fifo_ctrl.md
MON_FIFO_CTRL -- requirements
Module: mon_fifo_ctrl

Interface
REQ-001 SHALL have parameter DataWidth, default 16, meaning the monitor word width.
REQ-002 SHALL have parameter AddrWidth, default 5, meaning the memory address width; RamSize = 2**AddrWidth.
REQ-003 SHALL have parameter AFullLevel, default RamSize-4, meaning the AlmostFull threshold.
REQ-004 clk  in  1  single clock; all logic on rising edge.
REQ-005 Reset_b  in  1  reset, synchronous, active-low.
REQ-006 Clear  in  1  synchronous flush, same effect as reset.
REQ-007 WrEn  in  1  push request; WrData is accepted when WrEn=1 and Full=0.
REQ-008 WrData  in  DataWidth  push data.
REQ-009 RdReady  in  1  consumer pop; a word is popped when RdValid=1 and RdReady=1.
REQ-010 RdValid  out  1  RdData holds the oldest unread word.
REQ-011 RdData  out  DataWidth  head word, driven combinationally from MemOutData.
REQ-012 Full / AlmostFull / Empty  out  1 each  occupancy flags.
REQ-013 Count  out  AddrWidth+1  occupancy, 0..RamSize.
REQ-014 Overflow  out  1  sticky flag: a push was attempted while Full.
REQ-015 HighWater  out  AddrWidth+1  maximum Count since the last reset or Clear.
REQ-016 MemWrite, MemWrAddr[AddrWidth], MemInData[DataWidth]  out  drive the write port of the monitoring memory.
REQ-017 MemRdAddr  out  AddrWidth  drives the memory read address.
REQ-018 MemOutData  in  DataWidth  registered read data, equal to memory[MemRdAddr] sampled at the previous edge.

Function
REQ-019 SHALL keep the write pointer wptr and read pointer rptr, both AddrWidth bits, each wrapping modulo RamSize.
REQ-020 push = WrEn & ~Full; MemWrite = push; MemWrAddr = wptr; MemInData = WrData; wptr increments on push.
REQ-021 pop = RdValid & RdReady; rptr increments on pop; RdReady while RdValid=0 SHALL be ignored.
REQ-022 MemRdAddr = pop ? rptr+1 : rptr, evaluated combinationally, so the new head appears on MemOutData in the following cycle.
REQ-023 Count_next = Count + push - pop; a simultaneous push and pop leaves Count unchanged.
REQ-024 Full = (Count == RamSize); Empty = (Count == 0); AlmostFull = (Count >= AFullLevel); all three decoded from registered Count.
REQ-025 Output state machine SHALL have two states, NOVALID and VALID, and RdValid = (state == VALID).
REQ-026 Next state is VALID iff Count_next > 0 and NOT (push and MemWrAddr == MemRdAddr in the same cycle); otherwise the next state is NOVALID.
REQ-027 Latency: a word pushed in cycle N into an empty FIFO SHALL show RdValid=1 in cycle N+2.
REQ-028 Count=1 with simultaneous pop and push: the new head is being written at the address being read, so RdValid SHALL be 0 for exactly one cycle, then 1.
REQ-029 Push while Full: the word is dropped, wptr and Count are unchanged, and Overflow is set and held until reset or Clear.
REQ-030 Push while Full with a pop in the same cycle: Full is registered, so the push is still refused.
REQ-031 HighWater SHALL be updated to Count_next whenever Count_next > HighWater.
REQ-032 Clear SHALL have priority over WrEn and RdReady in the same cycle; MemWrite SHALL be 0 during Clear.

Reset
REQ-033 While Reset_b=0 or Clear=1 at an edge: wptr=0, rptr=0, Count=0, state=NOVALID, Overflow=0, HighWater=0.
REQ-034 After reset: RdValid=0, Full=0, AlmostFull=0, Empty=1, MemWrite=0, MemRdAddr=0.
REQ-035 Reset or Clear in mid-operation SHALL discard all stored words; memory contents are not erased.

Structure
REQ-036 The state enum (NOVALID, VALID) and default widths SHALL live in the shared monitor package mon_pkg.
REQ-037 No sub-module inside this block; the memory is instantiated alongside it at the next level and connected through the Mem* ports.

Verification
REQ-038 Reset, then push 0xA001 in cycle 0 -> RdValid=1 with RdData=0xA001 in cycle 2; Count=1.
REQ-039 Push 32 words with RdReady=0 -> Full=1 and Count=32; a 33rd push sets Overflow=1; draining returns all 32 words in order.
REQ-040 Count=1, pop and push 0xBEEF in the same cycle -> RdValid=0 for one cycle, then RdData=0xBEEF.
REQ-041 Run 100 words of continuous push and pop across pointer wrap -> data in order, HighWater <= 2.
REQ-042 Clear asserted with WrEn=1 and Count=10 -> next cycle Count=0, Empty=1, no memory write.
REQ-043 Count=28 (AlmostFull=1) with Reset_b low for one cycle -> all outputs at reset values per REQ-034.
